// File: rtl/policy_select_if.sv
`default_nettype none
// ============================================================================
// Module      : policy_select_if
// Description : Request / Q-table read / decision bundle for policy_select.
//               slave = the policy engine, master = requester plus Q-table.
// Revision    : 1.0 - initial release
// ============================================================================
interface policy_select_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                  start;
  logic [5:0]            state;
  logic [7:0]            eps;
  logic                  q_rd_en;
  logic [ADDR_WIDTH-1:0] q_addr;
  logic [DATA_WIDTH-1:0] q_data;
  logic                  busy;
  logic                  valid;
  logic [1:0]            action;
  logic [DATA_WIDTH-1:0] qbest;
  logic                  explore;

  modport slave (
    input  start, state, eps, q_data,
    output q_rd_en, q_addr, busy, valid, action, qbest, explore
  );

  modport master (
    output start, state, eps, q_data,
    input  q_rd_en, q_addr, busy, valid, action, qbest, explore
  );
endinterface
`default_nettype wire

// File: rtl/policy_select.sv
`default_nettype none
// ============================================================================
// Module      : policy_select
// Description : Epsilon-greedy action selection. Reads the four Q-values of
//               the latched state, keeps the greedy maximum, and replaces the
//               greedy action with an LFSR draw when the draw falls below eps.
// Revision    : 1.0 - initial release
// ============================================================================
module policy_select #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  policy_select_if.slave  bus
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_READ    = 2'd1;
  localparam logic [1:0]  S_DRAIN   = 2'd2;
  localparam logic [1:0]  S_DONE    = 2'd3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [1:0]            fsm_q;
  logic [1:0]            k_q;
  logic [5:0]            st_q;
  logic [7:0]            eps_q;
  logic                  cap_vld_q;
  logic [1:0]            cap_idx_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic [1:0]            arg_q;
  logic [15:0]           lfsr_q;
  logic [1:0]            action_q;
  logic [DATA_WIDTH-1:0] qbest_q;
  logic                  explore_q;

  logic [DATA_WIDTH-1:0] max_d;
  logic [1:0]            arg_d;
  logic                  explore_d;
  logic [15:0]           lfsr_d;
  logic [7:0]            addr8;

  // Running argmax including the Q-value arriving this cycle; action 0 seeds it
  // and only a strictly larger value moves it, so ties keep the lower index.
  always_comb begin
    max_d = max_q;
    arg_d = arg_q;
    if (cap_idx_q == 2'd0) begin
      max_d = bus.q_data;
      arg_d = 2'd0;
    end else if (bus.q_data > max_q) begin
      max_d = bus.q_data;
      arg_d = cap_idx_q;
    end
    explore_d = (lfsr_q[7:0] < eps_q);
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Sequencer: accept a request, issue four reads, wait out the read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      k_q   <= 2'd0;
      st_q  <= 6'd0;
      eps_q <= 8'd0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (bus.start) begin
            fsm_q <= S_READ;
            k_q   <= 2'd0;
            st_q  <= bus.state;
            eps_q <= bus.eps;
          end
        end
        S_READ: begin
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) fsm_q <= S_DRAIN;
        end
        S_DRAIN: fsm_q <= S_DONE;
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  // Capture read data one cycle after each read, tagged with its action index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= 2'd0;
      max_q     <= '0;
      arg_q     <= 2'd0;
    end else begin
      cap_vld_q <= (fsm_q == S_READ);
      cap_idx_q <= k_q;
      if (cap_vld_q) begin
        max_q <= max_d;
        arg_q <= arg_d;
      end
    end
  end

  // Decision registers load as the last Q-value lands, so they show in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      action_q  <= 2'd0;
      qbest_q   <= '0;
      explore_q <= 1'b0;
    end else if (fsm_q == S_DRAIN) begin
      qbest_q   <= max_d;
      explore_q <= explore_d;
      action_q  <= explore_d ? lfsr_q[9:8] : arg_d;
    end
  end

  // One LFSR step per completed decision, after DONE has used the value.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (fsm_q == S_DONE) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign addr8       = {st_q, k_q};
  assign bus.q_rd_en = (fsm_q == S_READ);
  assign bus.q_addr  = (fsm_q == S_READ) ? ADDR_WIDTH'(addr8) : '0;
  assign bus.busy    = (fsm_q == S_READ) || (fsm_q == S_DRAIN);
  assign bus.valid   = (fsm_q == S_DONE);
  assign bus.action  = action_q;
  assign bus.qbest   = qbest_q;
  assign bus.explore = explore_q;

endmodule
`default_nettype wire

// File: doc/policy_select.md
POLICY_SELECT -- requirements
Module: policy_select

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, Q-table address width; {state,action} is zero-extended when ADDR_WIDTH > 8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Q-value width.
REQ-003 SHALL use one clock and a synchronous, active-high reset:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have the following ports:
- start  input  1  request pulse; sampled only in IDLE.
- state  input  6  current state {x[2:0],y[2:0]}; latched on accepted start.
- eps  input  8  exploration threshold (0 = pure greedy).
- q_rd_en  output  1  Q-table read enable.
- q_addr  output  ADDR_WIDTH  Q-table read address {state,action}.
- q_data  input  DATA_WIDTH  Q-table read data, one-cycle registered latency.
- busy  output  1  high from the cycle after an accepted start until valid.
- valid  output  1  one-cycle pulse; decision ready.
- action  output  2  selected action (00 left, 01 up, 10 right, 11 down).
- qbest  output  DATA_WIDTH  greedy maximum Q of the latched state.
- explore  output  1  1 when action came from the random draw.

Function
REQ-005 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-006 IDLE->READ SHALL occur when start=1; start in any other state SHALL be ignored.
REQ-007 Let N be the cycle start is sampled; READ SHALL drive q_rd_en=1 and q_addr={state,k} in cycle N+1+k for k=0..3.
REQ-008 READ->DRAIN SHALL occur after k=3; DRAIN->DONE after one cycle; DONE->IDLE after one cycle.
REQ-009 q_rd_en SHALL be 0 outside READ.
REQ-010 q_data for action k SHALL be captured at the end of cycle N+2+k.
REQ-011 Running max SHALL use an unsigned, strictly-greater compare: action 0 initialises; a tie keeps the lower action index.
REQ-012 valid SHALL be 1 in cycle N+6 only (DONE); busy SHALL be 1 in cycles N+1..N+5.
REQ-013 A start in cycle N+6 SHALL be ignored; the earliest next accepted start SHALL be cycle N+7.
REQ-014 The 16-bit Fibonacci LFSR SHALL shift left with new bit0 = b15^b13^b12^b10.
REQ-015 The LFSR SHALL advance exactly once per decision, on the DONE->IDLE edge.
REQ-016 In DONE, explore SHALL be 1 if lfsr[7:0] < eps (unsigned compare), and action SHALL then be lfsr[9:8].
REQ-017 If lfsr[7:0] >= eps, explore SHALL be 0 and action SHALL be the greedy argmax.
REQ-018 eps=0 SHALL never explore.
REQ-019 qbest SHALL always be the greedy maximum, independent of explore.
REQ-020 action, qbest and explore SHALL update in the DONE cycle and hold until the next DONE.
REQ-021 state and eps SHALL be latched on start (eps latched for use in DONE); input changes mid-operation SHALL have no effect.
REQ-022 State 63 SHALL address 0xFC..0xFF; there SHALL be no wall masking (all four actions are eligible).

Reset
REQ-023 During rst, the FSM SHALL go to IDLE and outputs SHALL be: valid=0, busy=0, q_rd_en=0, q_addr=0, action=0, qbest=0, explore=0.
REQ-024 During rst, lfsr SHALL be 16'hACE1 and the latched state/eps SHALL be cleared.
REQ-025 rst SHALL take priority over start in the same cycle.
REQ-026 rst mid-operation SHALL abort the decision with no valid pulse and no output update.

Verification
REQ-027 Greedy tie: rst, then start state=5 eps=0 with Q(5,0..3)=10,40,40,7 -> q_addr 0x14,0x15,0x16,0x17 in N+1..N+4; valid at N+6; action=1, qbest=40, explore=0.
REQ-028 All-zero and unsigned compare:
- all Q=0 -> action=0, qbest=0.
- state=63, Q(63,3)=0xFFFFFFFF, others 0 -> q_addr 0xFC..0xFF; action=3, qbest=0xFFFFFFFF.
REQ-029 Explore: first decision after rst with eps=255, Q(s,2) max -> lfsr=0xACE1, low byte 0xE1<0xFF -> explore=1, action=0 (bits[9:8]=00), qbest still the greedy max.
REQ-030 Start handling:
- start pulses at N+2 and N+6 -> ignored; single valid at N+6.
- start at N+7 -> accepted; next valid at N+13.
REQ-031 Reset mid-operation: rst at N+3 -> busy=0 and q_rd_en=0 next cycle; no valid; action/qbest keep reset values; a later start completes normally in 6 cycles.
